// File: rtl/debug_cmd_pkg.sv
// Shared definitions for the VIO command injector: opcodes, FSM encoding and the
// bit layout of the probe_out command word and probe_in status word.
package debug_cmd_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  // Field order is MSB first, so the packed layout is the wire layout.
  typedef struct packed {
    logic        req;
    logic [2:0]  op;
    logic [3:0]  chip;
    logic [7:0]  rep;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_word_t;

  typedef struct packed {
    logic        ack;
    state_e      state;
    logic        busy;
    logic        timeout;
    logic        fail;
    logic        rsvd;
    logic [7:0]  remaining;
    logic [15:0] count;
    logic [31:0] rsp_data;
  } status_word_t;

  function automatic logic [7:0] norm_rep(input logic [7:0] rep);
    return (rep == 8'd0) ? 8'd1 : rep;
  endfunction

endpackage

// File: rtl/debug_watchdog.sv
// Saturating watchdog: expired_o once the counter reaches all-ones; clr_i wins over en_i.
// Expiry is registered-state based, visible the cycle after the final increment; no backpressure.
module debug_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign expired_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vio_cmd_injector.sv
// Turns VIO probe_out command words into valid/ready controller commands and reports status on probe_in.
// cmd_valid rises 2 cycles after a request toggle; cmd_* hold while cmd_ready is low until the watchdog expires.
module vio_cmd_injector
  import debug_cmd_pkg::*;
#(
  parameter int TIMEOUT_W = 20
) (
  input  logic        v_clk0,
  input  logic        v_rst0,
  input  logic [63:0] v_debug_vout,
  output logic [63:0] v_debug_vin,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [3:0]  cmd_chip,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_ok,
  input  logic [31:0] rsp_data
);

  state_e       state_q, state_d;
  cmd_word_t    vout_q;
  logic         ack_q, ack_d;
  logic         tog_q, tog_d;
  logic [2:0]   op_q, op_d;
  logic [3:0]   chip_q, chip_d;
  logic [15:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [7:0]   rem_q, rem_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [31:0]  rsp_q, rsp_d;
  logic         tmo_q, tmo_d;
  logic         fail_q, fail_d;

  logic         pending;
  logic         handshake;
  logic         wd_en;
  logic         wd_expired;
  status_word_t status;

  assign pending   = (vout_q.req != ack_q);
  assign wd_en     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  // Masking valid with expiry keeps a late cmd_ready from completing a timed-out command.
  assign cmd_valid = (state_q == ST_ISSUE) && !wd_expired;
  assign handshake = cmd_valid && cmd_ready;

  assign cmd_op   = op_q;
  assign cmd_chip = chip_q;
  assign cmd_addr = addr_q;
  assign cmd_data = data_q;

  debug_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk_i    (v_clk0),
    .rst_ni   (v_rst0),
    .clr_i    (!wd_en || handshake),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    tog_d   = tog_q;
    op_d    = op_q;
    chip_d  = chip_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    tmo_d   = tmo_q;
    fail_d  = fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending) begin
          tog_d  = vout_q.req;
          op_d   = vout_q.op;
          chip_d = vout_q.chip;
          addr_d = vout_q.addr;
          data_d = vout_q.data;
          tmo_d  = 1'b0;
          fail_d = 1'b0;
          if (vout_q.op == OP_NOP) begin
            state_d = ST_REPORT;
          end else if (vout_q.op == OP_CLR) begin
            state_d = ST_CLEAR;
          end else begin
            rem_d   = norm_rep(vout_q.rep);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_d = ST_WAIT;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          rsp_d   = rsp_data;
          fail_d  = !rsp_ok;
          cnt_d   = cnt_q + 16'd1;
          rem_d   = rem_q - 8'd1;
          addr_d  = addr_q + 16'd1;
          state_d = (!rsp_ok || rem_q == 8'd1) ? ST_REPORT : ST_ISSUE;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        rsp_d   = '0;
        tmo_d   = 1'b0;
        fail_d  = 1'b0;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        ack_d   = tog_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge v_clk0 or negedge v_rst0) begin
    if (!v_rst0) begin
      state_q <= ST_IDLE;
      vout_q  <= '0;
      ack_q   <= 1'b0;
      tog_q   <= 1'b0;
      op_q    <= '0;
      chip_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
      tmo_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vout_q  <= v_debug_vout;
      ack_q   <= ack_d;
      tog_q   <= tog_d;
      op_q    <= op_d;
      chip_q  <= chip_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      tmo_q   <= tmo_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    status           = '0;
    status.ack       = ack_q;
    status.state     = state_q;
    status.busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CLEAR);
    status.timeout   = tmo_q;
    status.fail      = fail_q;
    status.remaining = rem_q;
    status.count     = cnt_q;
    status.rsp_data  = rsp_q;
  end

  assign v_debug_vin = status;

endmodule
